// File: rtl/control_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the hardwired control sequencer of the single-bus CPU:
// IR field positions, opcode values, one-hot ALU operation codes, the sequencer
// state enum, and helpers that classify an opcode and map it to its ALU op.
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    // IR field bit positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    // Opcodes
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // One-hot ALU operation select
    localparam logic [11:0] ALU_ADD = 12'h001;
    localparam logic [11:0] ALU_SUB = 12'h002;
    localparam logic [11:0] ALU_AND = 12'h004;
    localparam logic [11:0] ALU_OR  = 12'h008;
    localparam logic [11:0] ALU_SHR = 12'h010;
    localparam logic [11:0] ALU_SHL = 12'h020;
    localparam logic [11:0] ALU_ROR = 12'h040;
    localparam logic [11:0] ALU_ROL = 12'h080;
    localparam logic [11:0] ALU_MUL = 12'h100;
    localparam logic [11:0] ALU_NEG = 12'h200;
    localparam logic [11:0] ALU_NOT = 12'h400;
    localparam logic [11:0] ALU_DIV = 12'h800;

    typedef enum logic [3:0] {
        S_RESET,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    // Execute-phase shape of an instruction
    typedef enum logic [2:0] {
        CLS_ALU3,     // Ra <= Rb op Rc
        CLS_UNARY,    // Ra <= op Rb
        CLS_MULDIV,   // HI:LO <= Ra op Rb
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    function automatic op_class_t op_class(input logic [4:0] opcode);
        case (opcode)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:   return CLS_ALU3;
            OP_NEG, OP_NOT:                  return CLS_UNARY;
            OP_MUL, OP_DIV:                  return CLS_MULDIV;
            OP_NOP:                          return CLS_NOP;
            OP_HALT:                         return CLS_HALT;
            default:                         return CLS_ILLEGAL;
        endcase
    endfunction

    function automatic logic [11:0] alu_select(input logic [4:0] opcode);
        case (opcode)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_SHR:  return ALU_SHR;
            OP_SHL:  return ALU_SHL;
            OP_ROR:  return ALU_ROR;
            OP_ROL:  return ALU_ROL;
            OP_MUL:  return ALU_MUL;
            OP_NEG:  return ALU_NEG;
            OP_NOT:  return ALU_NOT;
            OP_DIV:  return ALU_DIV;
            default: return 12'h000;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_reg_sel_decode.sv
// -----------------------------------------------------------------------------
// reg_sel_decode
// 4-to-16 one-hot register select decoder with enable.
//   en      in   1   when 0 the output is all zero
//   sel     in   4   register number
//   onehot  out 16   bit sel set when en=1
// -----------------------------------------------------------------------------
module reg_sel_decode (
    input  logic        en,
    input  logic [3:0]  sel,
    output logic [15:0] onehot
);

    // NOTE: every variable assigned in an always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Hardwired Moore control unit for the single-bus CPU datapath. Steps the fetch
// cycle (T0-T2), decodes IR and drives the datapath strobes for each execute
// step (T3-T6).
//   clock                    in   1   rising-edge clock
//   clr                      in   1   asynchronous active-low reset
//   run_en                   in   1   permits a new fetch, looked at only in T0
//   ir                       in  32   IR register contents
//   Rout / Rin               out 16   one-hot general register bus drive / load
//   PCout .. Cout            out  1   bus drivers (In_Portout, Cout, HIout,
//                                     LOout are never used by this ISA subset)
//   PCin .. LOin             out  1   register loads
//   incPC, MDRread           out  1   ALU increment / MDR source select
//   ALUin                    out 12   one-hot ALU operation
//   run                      out  1   1 outside RESET and HALT
//   illegal                  out  1   sticky undefined-opcode flag
// -----------------------------------------------------------------------------
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clock,
    input  logic        clr,
    input  logic        run_en,
    input  logic [31:0] ir,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic        PCout,
    output logic        MDRout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIout,
    output logic        LOout,
    output logic        In_Portout,
    output logic        Cout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zlow_in,
    output logic        Zhigh_in,
    output logic        HIin,
    output logic        LOin,
    output logic        incPC,
    output logic        MDRread,
    output logic [11:0] ALUin,
    output logic        run,
    output logic        illegal
);

    state_t    state, next_state;
    op_class_t cls;
    logic      set_illegal;
    logic      illegal_q;
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       rout_en, rin_en;
    logic [3:0] rout_sel, rin_sel;
    logic       unused_ir_bits;

    assign opcode = ir[OPC_MSB:OPC_LSB];
    assign ra     = ir[RA_MSB:RA_LSB];
    assign rb     = ir[RB_MSB:RB_LSB];
    assign rc     = ir[RC_MSB:RC_LSB];
    assign cls    = op_class(opcode);
    assign unused_ir_bits = ^ir[RC_LSB-1:0];

    // State register; the illegal flag is held here so it survives HALT.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            state     <= S_RESET;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Next-state logic. The T2 branch uses the incoming instruction word, so
    // IR must already hold it when T2 ends.
    always_comb begin
        next_state  = state;
        set_illegal = 1'b0;
        case (state)
            S_RESET: next_state = S_T0;
            S_T0:    next_state = run_en ? S_T1 : S_T0;
            S_T1:    next_state = S_T2;
            S_T2: begin
                case (cls)
                    CLS_NOP:  next_state = S_T0;
                    CLS_HALT: next_state = S_HALT;
                    CLS_ILLEGAL: begin
                        next_state  = HALT_ON_ILLEGAL ? S_HALT : S_T0;
                        set_illegal = HALT_ON_ILLEGAL;
                    end
                    default:  next_state = S_T3;
                endcase
            end
            // A class change during execute (unstable IR) falls back to fetch.
            S_T3: next_state = (cls inside {CLS_ALU3, CLS_UNARY, CLS_MULDIV}) ? S_T4 : S_T0;
            S_T4: next_state = (cls inside {CLS_ALU3, CLS_MULDIV}) ? S_T5 : S_T0;
            S_T5: next_state = (cls == CLS_MULDIV) ? S_T6 : S_T0;
            S_T6: next_state = S_T0;
            S_HALT: next_state = S_HALT;
            default: next_state = S_RESET;
        endcase
    end

    // Output decode from the state and IR (plus run_en gating the T0 fetch).
    always_comb begin
        PCout    = 1'b0;
        MDRout   = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        PCin     = 1'b0;
        IRin     = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        Yin      = 1'b0;
        Zlow_in  = 1'b0;
        Zhigh_in = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        incPC    = 1'b0;
        MDRread  = 1'b0;
        ALUin    = '0;
        run      = !(state inside {S_RESET, S_HALT});
        rout_en  = 1'b0;
        rout_sel = '0;
        rin_en   = 1'b0;
        rin_sel  = '0;
        case (state)
            S_T0: begin
                if (run_en) begin
                    PCout   = 1'b1;
                    MARin   = 1'b1;
                    incPC   = 1'b1;
                    Zlow_in = 1'b1;
                end
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                MDRread = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                case (cls)
                    CLS_ALU3: begin
                        rout_en = 1'b1; rout_sel = rb; Yin = 1'b1;
                    end
                    CLS_UNARY: begin
                        rout_en = 1'b1; rout_sel = rb;
                        ALUin = alu_select(opcode); Zlow_in = 1'b1; Zhigh_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        rout_en = 1'b1; rout_sel = ra; Yin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    CLS_ALU3: begin
                        rout_en = 1'b1; rout_sel = rc;
                        ALUin = alu_select(opcode); Zlow_in = 1'b1; Zhigh_in = 1'b1;
                    end
                    CLS_UNARY: begin
                        Zlowout = 1'b1; rin_en = 1'b1; rin_sel = ra;
                    end
                    CLS_MULDIV: begin
                        rout_en = 1'b1; rout_sel = rb;
                        ALUin = alu_select(opcode); Zlow_in = 1'b1; Zhigh_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    CLS_ALU3: begin
                        Zlowout = 1'b1; rin_en = 1'b1; rin_sel = ra;
                    end
                    CLS_MULDIV: begin
                        Zlowout = 1'b1; LOin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                if (cls == CLS_MULDIV) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign HIout      = 1'b0;
    assign LOout      = 1'b0;
    assign In_Portout = 1'b0;
    assign Cout       = 1'b0;
    assign illegal    = illegal_q;

    reg_sel_decode u_rout_dec (
        .en     (rout_en),
        .sel    (rout_sel),
        .onehot (Rout)
    );

    reg_sel_decode u_rin_dec (
        .en     (rin_en),
        .sel    (rin_sel),
        .onehot (Rin)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// Two sequencers (halt-on-illegal and execute-illegal-as-nop) share stimulus.
// Expected strobes per cycle come from a step table written from the
// instruction-level rules (fetch, then an execute pattern per opcode group).
// -----------------------------------------------------------------------------
module tb_control_sequencer;

    // Strobe vector bit positions
    localparam int B_ILL      = 0;
    localparam int B_RUN      = 1;
    localparam int B_MDR_READ = 2;
    localparam int B_INC_PC   = 3;
    localparam int B_LO_IN    = 4;
    localparam int B_HI_IN    = 5;
    localparam int B_ZHI_IN   = 6;
    localparam int B_ZLO_IN   = 7;
    localparam int B_Y_IN     = 8;
    localparam int B_MDR_IN   = 9;
    localparam int B_MAR_IN   = 10;
    localparam int B_IR_IN    = 11;
    localparam int B_PC_IN    = 12;
    localparam int B_ZLO_OUT  = 18;
    localparam int B_ZHI_OUT  = 17;
    localparam int B_MDR_OUT  = 19;
    localparam int B_PC_OUT   = 20;

    typedef struct packed {
        logic [15:0] rout;
        logic [15:0] rin;
        logic [11:0] alu;
        logic [20:0] sb;
    } exp_t;

    logic        clock = 1'b0;
    logic        clr = 1'b1;
    logic        run_en = 1'b0;
    logic [31:0] ir = '0;

    wire [15:0] a_rout, a_rin, b_rout, b_rin;
    wire [11:0] a_alu, b_alu;
    wire [20:0] a_sb, b_sb;

    int n_checks = 0;
    int n_fail = 0;
    int icount = 0;
    bit ill_a = 1'b0;

    logic [15:0] rec_rout [8];
    logic [15:0] rec_rin  [8];
    logic [11:0] rec_alu  [8];
    logic [20:0] rec_sb   [8];

    always #5 clock = ~clock;

    control_sequencer #(.HALT_ON_ILLEGAL(1'b1)) dut_a (
        .clock(clock), .clr(clr), .run_en(run_en), .ir(ir),
        .Rout(a_rout), .Rin(a_rin),
        .PCout(a_sb[20]), .MDRout(a_sb[19]), .Zlowout(a_sb[18]), .Zhighout(a_sb[17]),
        .HIout(a_sb[16]), .LOout(a_sb[15]), .In_Portout(a_sb[14]), .Cout(a_sb[13]),
        .PCin(a_sb[12]), .IRin(a_sb[11]), .MARin(a_sb[10]), .MDRin(a_sb[9]),
        .Yin(a_sb[8]), .Zlow_in(a_sb[7]), .Zhigh_in(a_sb[6]), .HIin(a_sb[5]),
        .LOin(a_sb[4]), .incPC(a_sb[3]), .MDRread(a_sb[2]), .ALUin(a_alu),
        .run(a_sb[1]), .illegal(a_sb[0])
    );

    control_sequencer #(.HALT_ON_ILLEGAL(1'b0)) dut_b (
        .clock(clock), .clr(clr), .run_en(run_en), .ir(ir),
        .Rout(b_rout), .Rin(b_rin),
        .PCout(b_sb[20]), .MDRout(b_sb[19]), .Zlowout(b_sb[18]), .Zhighout(b_sb[17]),
        .HIout(b_sb[16]), .LOout(b_sb[15]), .In_Portout(b_sb[14]), .Cout(b_sb[13]),
        .PCin(b_sb[12]), .IRin(b_sb[11]), .MARin(b_sb[10]), .MDRin(b_sb[9]),
        .Yin(b_sb[8]), .Zlow_in(b_sb[7]), .Zhigh_in(b_sb[6]), .HIin(b_sb[5]),
        .LOin(b_sb[4]), .incPC(b_sb[3]), .MDRread(b_sb[2]), .ALUin(b_alu),
        .run(b_sb[1]), .illegal(b_sb[0])
    );

    // ---------------- reference model ----------------
    // 1: Ra <= Rb op Rc, 2: Ra <= op Rb, 3: HI:LO <= Ra op Rb, 0: no execute
    function automatic int op_kind(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010: return 1;
            5'b10000, 5'b10001:                     return 2;
            5'b01110, 5'b01111:                     return 3;
            default:                                return 0;
        endcase
    endfunction

    function automatic logic [11:0] alu_code(input logic [4:0] op);
        case (op)
            5'b00011: return 12'h001;  // add
            5'b00100: return 12'h002;  // sub
            5'b01001: return 12'h004;  // and
            5'b01010: return 12'h008;  // or
            5'b00101: return 12'h010;  // shr
            5'b00110: return 12'h020;  // shl
            5'b00111: return 12'h040;  // ror
            5'b01000: return 12'h080;  // rol
            5'b01110: return 12'h100;  // mul
            5'b10000: return 12'h200;  // neg
            5'b10001: return 12'h400;  // not
            5'b01111: return 12'h800;  // div
            default:  return 12'h000;
        endcase
    endfunction

    function automatic int instr_len(input logic [4:0] op);
        case (op_kind(op))
            1:       return 6;
            2:       return 5;
            3:       return 7;
            default: return 3;
        endcase
    endfunction

    function automatic exp_t idle_exp(input bit run_v, input bit ill_v);
        exp_t e;
        e = '0;
        e.sb[B_RUN] = run_v;
        e.sb[B_ILL] = ill_v;
        return e;
    endfunction

    // Expected outputs for cycle k (0 = T0 with run_en high) of instruction w
    function automatic exp_t model_step(input logic [31:0] w, input int k, input bit ill_v);
        exp_t e;
        logic [3:0] ra, rb, rc;
        int kind;
        ra = w[26:23];
        rb = w[22:19];
        rc = w[18:15];
        kind = op_kind(w[31:27]);
        e = idle_exp(1'b1, ill_v);
        if (k == 0) begin
            e.sb[B_PC_OUT] = 1; e.sb[B_MAR_IN] = 1; e.sb[B_INC_PC] = 1; e.sb[B_ZLO_IN] = 1;
        end else if (k == 1) begin
            e.sb[B_ZLO_OUT] = 1; e.sb[B_PC_IN] = 1; e.sb[B_MDR_READ] = 1; e.sb[B_MDR_IN] = 1;
        end else if (k == 2) begin
            e.sb[B_MDR_OUT] = 1; e.sb[B_IR_IN] = 1;
        end else if (kind == 1) begin
            if (k == 3) begin e.rout = 16'h1 << rb; e.sb[B_Y_IN] = 1; end
            if (k == 4) begin
                e.rout = 16'h1 << rc; e.alu = alu_code(w[31:27]);
                e.sb[B_ZLO_IN] = 1; e.sb[B_ZHI_IN] = 1;
            end
            if (k == 5) begin e.rin = 16'h1 << ra; e.sb[B_ZLO_OUT] = 1; end
        end else if (kind == 2) begin
            if (k == 3) begin
                e.rout = 16'h1 << rb; e.alu = alu_code(w[31:27]);
                e.sb[B_ZLO_IN] = 1; e.sb[B_ZHI_IN] = 1;
            end
            if (k == 4) begin e.rin = 16'h1 << ra; e.sb[B_ZLO_OUT] = 1; end
        end else if (kind == 3) begin
            if (k == 3) begin e.rout = 16'h1 << ra; e.sb[B_Y_IN] = 1; end
            if (k == 4) begin
                e.rout = 16'h1 << rb; e.alu = alu_code(w[31:27]);
                e.sb[B_ZLO_IN] = 1; e.sb[B_ZHI_IN] = 1;
            end
            if (k == 5) begin e.sb[B_ZLO_OUT] = 1; e.sb[B_LO_IN] = 1; end
            if (k == 6) begin e.sb[B_ZHI_OUT] = 1; e.sb[B_HI_IN] = 1; end
        end
        return e;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cmp(input int which, input string tag, input exp_t e);
        if (which == 0) begin
            check({tag, ".rout"}, 32'(a_rout), 32'(e.rout));
            check({tag, ".rin"},  32'(a_rin),  32'(e.rin));
            check({tag, ".alu"},  32'(a_alu),  32'(e.alu));
            check({tag, ".sb"},   32'(a_sb),   32'(e.sb));
        end else begin
            check({tag, ".rout"}, 32'(b_rout), 32'(e.rout));
            check({tag, ".rin"},  32'(b_rin),  32'(e.rin));
            check({tag, ".alu"},  32'(b_alu),  32'(e.alu));
            check({tag, ".sb"},   32'(b_sb),   32'(e.sb));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Starts with the sequencers in T0 just after an edge; leaves them in the
    // state following the last executed step, just after its edge.
    task automatic run_instr(input logic [31:0] w, input bit chk_a, input bit chk_b,
                             input int max_steps, input bit rnd_en);
        int len;
        len = instr_len(w[31:27]);
        if (max_steps < len) len = max_steps;
        ir = w;
        run_en = 1'b1;
        for (int k = 0; k < len; k++) begin
            @(negedge clock);
            rec_rout[k] = a_rout;
            rec_rin[k]  = a_rin;
            rec_alu[k]  = a_alu;
            rec_sb[k]   = a_sb;
            if (chk_a) cmp(0, $sformatf("i%0d.s%0d.a", icount, k), model_step(w, k, ill_a));
            if (chk_b) cmp(1, $sformatf("i%0d.s%0d.b", icount, k), model_step(w, k, 1'b0));
            if (rnd_en && k > 0) run_en = 1'($urandom_range(0, 1));
            tick();
        end
        icount++;
    endtask

    task automatic idle_t0(input int n);
        run_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            cmp(0, $sformatf("idle%0d.a", i), idle_exp(1'b1, ill_a));
            cmp(1, $sformatf("idle%0d.b", i), idle_exp(1'b1, 1'b0));
            tick();
        end
    endtask

    task automatic do_reset();
        clr = 1'b0;
        #1;
        cmp(0, "rst.async.a", idle_exp(1'b0, 1'b0));
        cmp(1, "rst.async.b", idle_exp(1'b0, 1'b0));
        @(negedge clock);
        cmp(0, "rst.hold.a", idle_exp(1'b0, 1'b0));
        cmp(1, "rst.hold.b", idle_exp(1'b0, 1'b0));
        clr = 1'b1;
        ill_a = 1'b0;
        run_en = 1'b1;
        tick();
        cmp(0, "rst.t0.a", model_step(ir, 0, 1'b0));
        cmp(1, "rst.t0.b", model_step(ir, 0, 1'b0));
    endtask

    // ---------------- stimulus ----------------
    logic [4:0] legal_ops [14] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                   5'b01000, 5'b01001, 5'b01010, 5'b01110, 5'b01111,
                                   5'b10000, 5'b10001, 5'b11010, 5'b11011};

    initial begin
        logic [31:0] r;
        logic [31:0] w;
        #2;
        do_reset();
        idle_t0(3);

        // and R5,R2,R4
        run_instr(32'h4A920000, 1, 1, 99, 0);
        check("and.T3.rout", 32'(rec_rout[3]), 32'h0004);
        check("and.T3.yin",  32'(rec_sb[3][B_Y_IN]), 32'h1);
        check("and.T4.rout", 32'(rec_rout[4]), 32'h0010);
        check("and.T4.alu",  32'(rec_alu[4]), 32'h004);
        check("and.T5.rin",  32'(rec_rin[5]), 32'h0020);
        check("and.T5.zlo",  32'(rec_sb[5][B_ZLO_OUT]), 32'h1);
        check("and.len6.t0", 32'({a_sb[B_PC_OUT], a_sb[B_MAR_IN]}), 32'h3);

        // neg R5,R2
        run_instr(32'h82900000, 1, 1, 99, 0);
        check("neg.T3.rout", 32'(rec_rout[3]), 32'h0004);
        check("neg.T3.alu",  32'(rec_alu[3]), 32'h200);
        check("neg.T3.z",    32'({rec_sb[3][B_ZLO_IN], rec_sb[3][B_ZHI_IN]}), 32'h3);
        check("neg.T4.rin",  32'(rec_rin[4]), 32'h0020);
        check("neg.len5.t0", 32'({a_sb[B_PC_OUT], a_sb[B_MAR_IN]}), 32'h3);

        // mul R3,R1
        run_instr(32'h71880000, 1, 1, 99, 0);
        check("mul.T5.lo",   32'({rec_sb[5][B_LO_IN], rec_sb[5][B_ZLO_OUT]}), 32'h3);
        check("mul.T6.hi",   32'({rec_sb[6][B_HI_IN], rec_sb[6][B_ZHI_OUT]}), 32'h3);
        check("mul.len7.t0", 32'({a_sb[B_PC_OUT], a_sb[B_MAR_IN]}), 32'h3);

        // clr during T4 of an add: no Rin pulse, back to T0 after release
        run_instr(32'h1A920000, 1, 1, 4, 0);
        #2;
        clr = 1'b0;
        #1;
        cmp(0, "abort.a", idle_exp(1'b0, 1'b0));
        cmp(1, "abort.b", idle_exp(1'b0, 1'b0));
        tick();
        cmp(0, "abort.hold.a", idle_exp(1'b0, 1'b0));
        @(negedge clock);
        clr = 1'b1;
        tick();
        cmp(0, "abort.t0.a", model_step(ir, 0, 1'b0));
        cmp(1, "abort.t0.b", model_step(ir, 0, 1'b0));

        // halt
        run_instr(32'hD8000000, 1, 1, 99, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            cmp(0, $sformatf("halt%0d.a", i), idle_exp(1'b0, 1'b0));
            cmp(1, $sformatf("halt%0d.b", i), idle_exp(1'b0, 1'b0));
        end
        tick();
        do_reset();

        // opcode 11111: a halts flagged, b carries on as a nop
        r = $urandom();
        run_instr({5'b11111, r[26:0]}, 1, 1, 99, 0);
        ill_a = 1'b1;
        cmp(0, "ill.halt.a", idle_exp(1'b0, 1'b1));
        cmp(1, "ill.t0.b", model_step(ir, 0, 1'b0));
        run_instr(32'h1A920000, 0, 1, 99, 0);
        cmp(0, "ill.sticky.a", idle_exp(1'b0, 1'b1));
        r = $urandom();
        run_instr({5'b00000, r[26:0]}, 0, 1, 99, 0);
        cmp(1, "ill0.t0.b", model_step(ir, 0, 1'b0));
        cmp(0, "ill.sticky2.a", idle_exp(1'b0, 1'b1));
        do_reset();

        // randomized legal traffic with idle gaps and mid-instruction run_en noise
        for (int n = 0; n < 60; n++) begin
            int idx;
            idle_t0(int'($urandom_range(0, 2)));
            idx = ($urandom_range(0, 19) == 0) ? 13 : int'($urandom_range(0, 12));
            r = $urandom();
            w = {legal_ops[idx], r[26:0]};
            run_instr(w, 1, 1, 99, 1);
            if (idx == 13) begin
                cmp(0, $sformatf("rhalt%0d.a", n), idle_exp(1'b0, 1'b0));
                cmp(1, $sformatf("rhalt%0d.b", n), idle_exp(1'b0, 1'b0));
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
